// File: rtl/ps2_mouse_pktbuf_pkg.sv
// ps2m_pkg: shared constants and types for the PS2 mouse packet buffer.
//   - packet lengths (standard 3-byte, IntelliMouse 4-byte)
//   - common PS2 device reply codes
//   - FSM state encoding used by ps2_mouse_pktbuf
package ps2m_pkg;

  localparam logic [2:0] PS2M_PKT_LEN3 = 3'd3;
  localparam logic [2:0] PS2M_PKT_LEN4 = 3'd4;

  localparam logic [7:0] PS2M_ACK    = 8'hFA;
  localparam logic [7:0] PS2M_RESEND = 8'hFE;
  localparam logic [7:0] PS2M_ERR    = 8'hFC;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_DISCARD = 2'd2
  } ps2m_state_t;

endpackage

// File: rtl/ps2_mouse_pktbuf_commit_fifo.sv
// ps2m_commit_fifo: byte FIFO with a speculative write pointer.
// Bytes are written at the speculative pointer and only become visible to the
// reader when committed; rollback discards everything since the last commit.
// Ports:
//   clk6x/resetn   clock, synchronous active-low reset
//   i_wr/i_wdata   speculative write
//   i_commit       publish speculative pointer (includes a same-cycle write)
//   i_rollback     speculative pointer := committed pointer
//   i_deq          pop head (ignored when empty)
//   o_rdata        head byte, 0x00 when empty
//   o_rvalid       committed data available
//   o_free         free bytes, measured between read and committed pointers
module ps2m_commit_fifo #(
  parameter int AW = 4
) (
  input  logic        clk6x,
  input  logic        resetn,
  input  logic        i_wr,
  input  logic [7:0]  i_wdata,
  input  logic        i_commit,
  input  logic        i_rollback,
  input  logic        i_deq,
  output logic [7:0]  o_rdata,
  output logic        o_rvalid,
  output logic [AW:0] o_free
);
  localparam int DEPTH = 2**AW;

  logic [7:0]  r_mem [DEPTH];
  logic [AW:0] r_rptr, r_cptr, r_sptr;
  logic [AW:0] w_sptr_nxt;

  assign w_sptr_nxt = i_wr ? r_sptr + 1'b1 : r_sptr;

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      r_rptr <= '0;
      r_cptr <= '0;
      r_sptr <= '0;
    end else begin
      r_sptr <= i_rollback ? r_cptr : w_sptr_nxt;
      // commit takes the post-write pointer so the final byte lands atomically
      if (i_commit)           r_cptr <= w_sptr_nxt;
      if (i_deq && o_rvalid)  r_rptr <= r_rptr + 1'b1;
    end
  end

  always_ff @(posedge clk6x) begin
    if (i_wr) r_mem[r_sptr[AW-1:0]] <= i_wdata;
  end

  assign o_rvalid = (r_cptr != r_rptr);
  assign o_rdata  = o_rvalid ? r_mem[r_rptr[AW-1:0]] : 8'h00;
  // extra pointer bit makes full (16) distinguishable from empty (0)
  assign o_free   = (AW+1)'(DEPTH) - (r_cptr - r_rptr);

endmodule

// File: rtl/ps2_mouse_pktbuf.sv
// ps2_mouse_pktbuf: groups PS2 mouse bytes into whole packets, checks sync
// (bit3 of byte 0), drops partial/late/overflowing packets, and queues only
// complete packets for the SMC mouse-buffer read path.
// Optional: define PS2M_WHEEL_EN to add wheel_mode_i (4-byte packets when 1,
// sampled at packet start).
// Ports:
//   clk6x, resetn(sync, low), ck1us  clock / reset / 1us tick
//   rx_byte_i, rx_byte_v_i, rx_err_i PS2 receiver byte stream
//   cmd_pend_i                       next IDLE byte is a command reply
//   m_rdata_o, m_rvalid_o, m_rdeq_i  FIFO read side
//   m_stat_o, reply_v_o              last reply byte / capture pulse
//   drop_cnt_o                       saturating dropped-packet counter
module ps2_mouse_pktbuf
  import ps2m_pkg::*;
#(
  parameter int FIFO_AW    = 4,
  parameter int TIMEOUT_US = 2000
) (
  input  logic       clk6x,
  input  logic       resetn,
  input  logic       ck1us,
`ifdef PS2M_WHEEL_EN
  input  logic       wheel_mode_i,
`endif
  input  logic [7:0] rx_byte_i,
  input  logic       rx_byte_v_i,
  input  logic       rx_err_i,
  input  logic       cmd_pend_i,
  output logic [7:0] m_rdata_o,
  output logic       m_rvalid_o,
  input  logic       m_rdeq_i,
  output logic [7:0] m_stat_o,
  output logic       reply_v_o,
  output logic [7:0] drop_cnt_o
);
  localparam int TW = $clog2(TIMEOUT_US + 1);

  ps2m_state_t      r_state, w_nxt;
  logic [2:0]       r_idx, w_idx_nxt;
  logic [2:0]       r_plen, w_len_start;
  logic [TW-1:0]    r_tmo;
  logic [7:0]       r_stat, r_drop;
  logic             r_reply_v;
  logic             w_wr, w_commit, w_rollback, w_drop_inc, w_stat_ld, w_plen_ld;
  logic             w_tmo_hit;
  logic [FIFO_AW:0] w_free;

`ifdef PS2M_WHEEL_EN
  assign w_len_start = wheel_mode_i ? PS2M_PKT_LEN4 : PS2M_PKT_LEN3;
`else
  assign w_len_start = PS2M_PKT_LEN3;
`endif

  assign w_tmo_hit = (r_state != ST_IDLE) && (r_tmo == TW'(TIMEOUT_US));

  always_ff @(posedge clk6x) begin
    if (!resetn) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_plen    <= PS2M_PKT_LEN3;
      r_tmo     <= '0;
      r_stat    <= 8'h00;
      r_reply_v <= 1'b0;
      r_drop    <= 8'h00;
    end else begin
      r_state   <= w_nxt;
      r_idx     <= w_idx_nxt;
      r_reply_v <= w_stat_ld;
      if (w_plen_ld) r_plen <= w_len_start;
      if (w_stat_ld) r_stat <= rx_byte_i;
      if (w_drop_inc && r_drop != 8'hFF) r_drop <= r_drop + 8'd1;
      if (rx_byte_v_i || w_nxt == ST_IDLE) r_tmo <= '0;
      else if (ck1us && r_state != ST_IDLE) r_tmo <= r_tmo + 1'b1;
    end
  end

  always_comb begin
    w_nxt      = r_state;
    w_idx_nxt  = r_idx;
    w_wr       = 1'b0;
    w_commit   = 1'b0;
    w_rollback = 1'b0;
    w_drop_inc = 1'b0;
    w_stat_ld  = 1'b0;
    w_plen_ld  = 1'b0;
    if (rx_err_i) begin
      // error wins over a same-cycle byte; that byte is thrown away
      w_rollback = 1'b1;
      w_drop_inc = (r_state != ST_IDLE);
      w_nxt      = ST_IDLE;
      w_idx_nxt  = '0;
    end else if (w_tmo_hit) begin
      w_rollback = 1'b1;
      w_drop_inc = 1'b1;
      w_nxt      = ST_IDLE;
      w_idx_nxt  = '0;
    end else if (rx_byte_v_i) begin
      unique case (r_state)
        ST_IDLE: begin
          if (cmd_pend_i) begin
            w_stat_ld = 1'b1;
          end else if (rx_byte_i[3]) begin
            w_plen_ld = 1'b1;
            w_idx_nxt = 3'd1;
            if (w_free >= (FIFO_AW+1)'(w_len_start)) begin
              w_wr  = 1'b1;
              w_nxt = ST_COLLECT;
            end else begin
              w_drop_inc = 1'b1;
              w_nxt      = ST_DISCARD;
            end
          end
        end
        ST_COLLECT: begin
          w_wr = 1'b1;
          if (r_idx + 3'd1 == r_plen) begin
            w_commit  = 1'b1;
            w_nxt     = ST_IDLE;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
        ST_DISCARD: begin
          if (r_idx + 3'd1 == r_plen) begin
            w_nxt     = ST_IDLE;
            w_idx_nxt = '0;
          end else begin
            w_idx_nxt = r_idx + 3'd1;
          end
        end
        default: begin
          w_nxt     = ST_IDLE;
          w_idx_nxt = '0;
        end
      endcase
    end
  end

  ps2m_commit_fifo #(.AW(FIFO_AW)) u_fifo (
    .clk6x      (clk6x),
    .resetn     (resetn),
    .i_wr       (w_wr),
    .i_wdata    (rx_byte_i),
    .i_commit   (w_commit),
    .i_rollback (w_rollback),
    .i_deq      (m_rdeq_i),
    .o_rdata    (m_rdata_o),
    .o_rvalid   (m_rvalid_o),
    .o_free     (w_free)
  );

  assign m_stat_o   = r_stat;
  assign reply_v_o  = r_reply_v;
  assign drop_cnt_o = r_drop;

endmodule
